// File: rtl/uart_cmd_pkg.sv
// Shared opcodes, response codes and FSM encoding for uart_cmd_responder.
// Optional UART_CMD_CHECKSUM_EN adds the CSUM state.
package uart_cmd_pkg;

    localparam logic [7:0] OP_READ    = 8'h01;
    localparam logic [7:0] OP_WRITE   = 8'h02;

    localparam logic [7:0] RSP_READ   = 8'hA1;
    localparam logic [7:0] RSP_WRITE  = 8'hA2;
    localparam logic [7:0] RSP_BADOP  = 8'hEE;
    localparam logic [7:0] RSP_BADSUM = 8'hEC;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP   = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_MEM  = 3'd4,
        ST_RESP = 3'd5,
`ifdef UART_CMD_CHECKSUM_EN
        ST_ERR  = 3'd6,
        ST_CSUM = 3'd7
`else
        ST_ERR  = 3'd6
`endif
    } state_e;

    function automatic logic [7:0] xor_bytes(input logic [31:0] w);
        return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    endfunction

endpackage

// File: rtl/uart_cmd_timeout.sv
// Inter-byte idle counter: clear wins over enable, saturates at LIMIT.
module uart_cmd_timeout #(
    parameter int unsigned LIMIT = 100000000
) (
    input  logic CLK,
    input  logic RST,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired = (cnt_q == W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Host command responder: UART packets in, one 32-bit memory access, response out.
// Define UART_CMD_CHECKSUM_EN for trailing XOR bytes on commands and responses.
module uart_cmd_responder #(
    parameter int unsigned TIMEOUT_CYCLES = 100000000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  recv_data,
    input  logic        receivable,
    output logic        recv_flag,
    output logic [7:0]  send_data,
    input  logic        sendable,
    output logic        send_flag,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
);

    import uart_cmd_pkg::*;

`ifdef UART_CMD_CHECKSUM_EN
    localparam state_e     ST_HDR_DONE = ST_CSUM;
    localparam logic [2:0] RD_LEN      = 3'd6;
    localparam logic [2:0] WR_LEN      = 3'd2;
`else
    localparam state_e     ST_HDR_DONE = ST_MEM;
    localparam logic [2:0] RD_LEN      = 3'd5;
    localparam logic [2:0] WR_LEN      = 3'd1;
`endif

    state_e      state_q, state_d;
    logic [7:0]  op_q, op_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [47:0] resp_q, resp_d;
    logic [2:0]  left_q, left_d;
    logic [7:0]  send_data_q, send_data_d;
    logic        recv_flag_q, recv_flag_d;
    logic        send_flag_q, send_flag_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic        busy_q, busy_d;
    logic        counting, expecting, expired, take, push, op_ok;
`ifdef UART_CMD_CHECKSUM_EN
    logic [7:0]  csum_q, csum_d;
`endif

`ifdef UART_CMD_CHECKSUM_EN
    assign counting = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    assign counting = (state_q == ST_ADDR) || (state_q == ST_DATA);
`endif
    assign expecting = counting || (state_q == ST_IDLE);
    assign take  = expecting && receivable && !recv_flag_q && !(counting && expired);
    assign push  = ((state_q == ST_RESP) || (state_q == ST_ERR)) && sendable && !send_flag_q;
    assign op_ok = (op_q == OP_READ) || (op_q == OP_WRITE);

    uart_cmd_timeout #(
        .LIMIT   (TIMEOUT_CYCLES)
    ) u_timeout (
        .CLK     (CLK),
        .RST     (RST),
        .clr     (recv_flag_q || !counting),
        .en      (!receivable),
        .expired (expired)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= ST_IDLE;
            op_q        <= '0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            resp_q      <= '0;
            left_q      <= '0;
            send_data_q <= '0;
            recv_flag_q <= 1'b0;
            send_flag_q <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            busy_q      <= 1'b0;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            resp_q      <= resp_d;
            left_q      <= left_d;
            send_data_q <= send_data_d;
            recv_flag_q <= recv_flag_d;
            send_flag_q <= send_flag_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            busy_q      <= busy_d;
`ifdef UART_CMD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (take) state_d = ST_OP;
            ST_OP:   state_d = op_ok ? ST_ADDR : ST_ERR;
            ST_ADDR: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (take && cnt_q == 2'd3) begin
                    state_d = (op_q == OP_WRITE) ? ST_DATA : ST_HDR_DONE;
                end
            end
            ST_DATA: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (take && cnt_q == 2'd3) begin
                    state_d = ST_HDR_DONE;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                if (expired) begin
                    state_d = ST_IDLE;
                end else if (take) begin
                    state_d = (recv_data == csum_q) ? ST_MEM : ST_ERR;
                end
            end
`endif
            ST_MEM:  if (mem_ack) state_d = ST_RESP;
            ST_RESP,
            ST_ERR:  if (push && left_q == 3'd1) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        op_d        = op_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        resp_d      = resp_q;
        left_d      = left_q;
        send_data_d = send_data_q;
        mem_we_d    = mem_we_q;
        recv_flag_d = take;
        send_flag_d = push;
        mem_req_d   = (state_d == ST_MEM);
        busy_d      = (state_d != ST_IDLE);
`ifdef UART_CMD_CHECKSUM_EN
        csum_d      = csum_q;
        if (take && state_q != ST_CSUM) csum_d = csum_q ^ recv_data;
        if (state_q == ST_IDLE) csum_d = recv_data;
`endif
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (take) op_d = recv_data;
            end
            ST_OP: begin
                mem_we_d = (op_q == OP_WRITE);
                resp_d   = {40'h0, RSP_BADOP};
                left_d   = 3'd1;
            end
            // Little-endian fields: shift in from the top so byte 0 lands in [7:0].
            ST_ADDR: begin
                if (take) begin
                    addr_d = {recv_data, addr_q[31:8]};
                    cnt_d  = cnt_q + 2'd1;
                end
            end
            ST_DATA: begin
                if (take) begin
                    wdata_d = {recv_data, wdata_q[31:8]};
                    cnt_d   = cnt_q + 2'd1;
                end
            end
`ifdef UART_CMD_CHECKSUM_EN
            ST_CSUM: begin
                resp_d = {40'h0, RSP_BADSUM};
                left_d = 3'd1;
            end
`endif
            ST_MEM: begin
                if (mem_ack && mem_we_q) begin
                    resp_d = {40'h0, RSP_WRITE};
                    left_d = WR_LEN;
`ifdef UART_CMD_CHECKSUM_EN
                    resp_d[15:8] = RSP_WRITE;
`endif
                end else if (mem_ack) begin
                    resp_d = {8'h0, mem_rdata, RSP_READ};
                    left_d = RD_LEN;
`ifdef UART_CMD_CHECKSUM_EN
                    resp_d[47:40] = RSP_READ ^ xor_bytes(mem_rdata);
`endif
                end
            end
            ST_RESP,
            ST_ERR: begin
                if (push) begin
                    send_data_d = resp_q[7:0];
                    resp_d      = {8'h0, resp_q[47:8]};
                    left_d      = left_q - 3'd1;
                end
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign recv_flag = recv_flag_q;
    assign send_flag = send_flag_q;
    assign send_data = send_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder with FIFO and memory models.
// Define UART_CMD_CHECKSUM_EN to exercise the checksum build.
module tb_uart_cmd_responder;

    typedef logic [7:0] bq_t[$];

`ifdef UART_CMD_CHECKSUM_EN
    localparam int WR_LEN = 2;
`else
    localparam int WR_LEN = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [7:0]  recv_data = 8'h00;
    logic        receivable = 1'b0;
    logic        recv_flag;
    logic [7:0]  send_data;
    logic        sendable = 1'b1;
    logic        send_flag;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rxq[$];
    logic [7:0]  txq[$];
    int          ack_delay = 1;
    int          req_cnt = 0;
    int          n_mem = 0;
    int          last_len = 0;
    int          unstable = 0;
    logic        last_we = 1'b0;
    logic [31:0] last_addr = '0;
    logic [31:0] last_wdata = '0;
    logic [31:0] first_addr = '0;

    uart_cmd_responder #(
        .TIMEOUT_CYCLES (50)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .recv_data  (recv_data),
        .receivable (receivable),
        .recv_flag  (recv_flag),
        .send_data  (send_data),
        .sendable   (sendable),
        .send_flag  (send_flag),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    // Receive FIFO, send FIFO and memory slave, all updated on the falling edge.
    always @(negedge CLK) begin
        if (recv_flag && rxq.size() > 0) void'(rxq.pop_front());
        receivable = (rxq.size() > 0);
        recv_data  = receivable ? rxq[0] : 8'h00;
        if (send_flag) txq.push_back(send_data);
        if (mem_req) begin
            req_cnt++;
            if (req_cnt == 1) first_addr = mem_addr;
            if (mem_addr !== first_addr) unstable++;
            mem_ack = (req_cnt == ack_delay);
            if (mem_ack) begin
                n_mem++;
                last_len   = req_cnt;
                last_we    = mem_we;
                last_addr  = mem_addr;
                last_wdata = mem_wdata;
            end
        end else begin
            req_cnt = 0;
            mem_ack = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLK);
            #1;
        end
    endtask

    task automatic wait_tx(input int n);
        for (int i = 0; i < 400 && txq.size() < n; i++) tick(1);
        tick(6);
    endtask

    task automatic push_pkt(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] d, input bit wr);
        logic [7:0] x;
        x = op;
        rxq.push_back(op);
        for (int i = 0; i < 4; i++) begin
            rxq.push_back(a[8*i +: 8]);
            x ^= a[8*i +: 8];
        end
        if (wr) begin
            for (int i = 0; i < 4; i++) begin
                rxq.push_back(d[8*i +: 8]);
                x ^= d[8*i +: 8];
            end
        end
`ifdef UART_CMD_CHECKSUM_EN
        rxq.push_back(x);
`endif
    endtask

    function automatic bq_t rd_rsp(input logic [31:0] d);
        bq_t q;
        logic [7:0] x;
        x = 8'hA1;
        q.push_back(8'hA1);
        for (int i = 0; i < 4; i++) begin
            q.push_back(d[8*i +: 8]);
            x ^= d[8*i +: 8];
        end
`ifdef UART_CMD_CHECKSUM_EN
        q.push_back(x);
`endif
        return q;
    endfunction

    task automatic test_reset();
        tick(2);
        checks++;
        if (recv_flag !== 1'b0) begin
            failures++; $display("FAIL rst_recv_flag got=%b exp=0", recv_flag);
        end
        checks++;
        if (send_flag !== 1'b0) begin
            failures++; $display("FAIL rst_send_flag got=%b exp=0", send_flag);
        end
        checks++;
        if (mem_req !== 1'b0) begin
            failures++; $display("FAIL rst_mem_req got=%b exp=0", mem_req);
        end
        checks++;
        if (mem_we !== 1'b0) begin
            failures++; $display("FAIL rst_mem_we got=%b exp=0", mem_we);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL rst_busy got=%b exp=0", busy);
        end
        checks++;
        if (send_data !== 8'h00) begin
            failures++; $display("FAIL rst_send_data got=%h exp=00", send_data);
        end
        checks++;
        if ({mem_addr, mem_wdata} !== 64'h0) begin
            failures++;
            $display("FAIL rst_mem_bus got=%h/%h exp=0/0", mem_addr, mem_wdata);
        end
        RST = 1'b0;
        tick(2);
    endtask

    task automatic test_write();
        int n0;
        n0 = n_mem;
        txq.delete();
        ack_delay = 1;
        push_pkt(8'h02, 32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
        wait_tx(WR_LEN);
        checks++;
        if (n_mem !== n0 + 1) begin
            failures++; $display("FAIL wr_count got=%0d exp=%0d", n_mem - n0, 1);
        end
        checks++;
        if (last_we !== 1'b1 || last_len !== 1) begin
            failures++; $display("FAIL wr_we_len got=%b/%0d exp=1/1", last_we, last_len);
        end
        checks++;
        if (last_addr !== 32'h10) begin
            failures++; $display("FAIL wr_addr got=%h exp=00000010", last_addr);
        end
        checks++;
        if (last_wdata !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL wr_wdata got=%h exp=deadbeef", last_wdata);
        end
        checks++;
        if (txq.size() !== WR_LEN) begin
            failures++; $display("FAIL wr_rsp_len got=%0d exp=%0d", txq.size(), WR_LEN);
        end
        for (int i = 0; i < WR_LEN; i++) begin
            checks++;
            if (txq[i] !== 8'hA2) begin
                failures++; $display("FAIL wr_rsp[%0d] got=%h exp=a2", i, txq[i]);
            end
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL wr_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_read_late();
        bq_t exp;
        txq.delete();
        ack_delay = 5;
        mem_rdata = 32'h1234_5678;
        unstable = 0;
        push_pkt(8'h01, 32'h0000_0010, 32'h0, 1'b0);
        exp = rd_rsp(32'h1234_5678);
        wait_tx(exp.size());
        checks++;
        if (last_len !== 5 || last_we !== 1'b0) begin
            failures++; $display("FAIL rd_req_len got=%0d/%b exp=5/0", last_len, last_we);
        end
        checks++;
        if (last_addr !== 32'h10 || unstable !== 0) begin
            failures++; $display("FAIL rd_addr got=%h/%0d exp=00000010/0", last_addr, unstable);
        end
        checks++;
        if (txq.size() !== exp.size()) begin
            failures++; $display("FAIL rd_rsp_len got=%0d exp=%0d", txq.size(), exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (txq[i] !== exp[i]) begin
                failures++; $display("FAIL rd_rsp[%0d] got=%h exp=%h", i, txq[i], exp[i]);
            end
        end
        ack_delay = 1;
    endtask

    task automatic test_bad_opcode();
        bq_t exp;
        int n0;
        n0 = n_mem;
        txq.delete();
        mem_rdata = 32'hCAFE_F00D;
        rxq.push_back(8'h7F);
        push_pkt(8'h01, 32'h0000_0020, 32'h0, 1'b0);
        exp = rd_rsp(32'hCAFE_F00D);
        exp.push_front(8'hEE);
        wait_tx(exp.size());
        checks++;
        if (n_mem !== n0 + 1 || last_addr !== 32'h20) begin
            failures++;
            $display("FAIL badop_mem got=%0d/%h exp=1/00000020", n_mem - n0, last_addr);
        end
        checks++;
        if (txq.size() !== exp.size()) begin
            failures++; $display("FAIL badop_len got=%0d exp=%0d", txq.size(), exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (txq[i] !== exp[i]) begin
                failures++; $display("FAIL badop_rsp[%0d] got=%h exp=%h", i, txq[i], exp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        bq_t exp;
        int n0;
        n0 = n_mem;
        txq.delete();
        rxq.push_back(8'h01);
        rxq.push_back(8'h10);
        rxq.push_back(8'h00);
        tick(20);
        checks++;
        if (busy !== 1'b1) begin
            failures++; $display("FAIL to_busy_mid got=%b exp=1", busy);
        end
        tick(60);
        checks++;
        if (busy !== 1'b0) begin
            failures++; $display("FAIL to_busy_end got=%b exp=0", busy);
        end
        checks++;
        if (n_mem !== n0 || txq.size() !== 0 || rxq.size() !== 0) begin
            failures++;
            $display("FAIL to_quiet got=%0d/%0d/%0d exp=0/0/0", n_mem - n0, txq.size(), rxq.size());
        end
        mem_rdata = 32'h0BAD_CAFE;
        push_pkt(8'h01, 32'h0000_0030, 32'h0, 1'b0);
        exp = rd_rsp(32'h0BAD_CAFE);
        wait_tx(exp.size());
        checks++;
        if (txq.size() !== exp.size() || last_addr !== 32'h30) begin
            failures++;
            $display("FAIL to_next got=%0d/%h exp=%0d/00000030", txq.size(), last_addr, exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (txq[i] !== exp[i]) begin
                failures++; $display("FAIL to_rsp[%0d] got=%h exp=%h", i, txq[i], exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        bq_t exp;
        txq.delete();
        ack_delay = 2;
        mem_rdata = 32'h8765_4321;
        push_pkt(8'h01, 32'h0000_0040, 32'h0, 1'b0);
        exp = rd_rsp(32'h8765_4321);
        for (int i = 0; i < 400 && txq.size() < 2; i++) tick(1);
        sendable = 1'b0;
        tick(20);
        checks++;
        if (txq.size() !== 2 || busy !== 1'b1) begin
            failures++; $display("FAIL stall_hold got=%0d/%b exp=2/1", txq.size(), busy);
        end
        sendable = 1'b1;
        wait_tx(exp.size());
        checks++;
        if (txq.size() !== exp.size()) begin
            failures++; $display("FAIL stall_len got=%0d exp=%0d", txq.size(), exp.size());
        end
        foreach (exp[i]) begin
            checks++;
            if (txq[i] !== exp[i]) begin
                failures++; $display("FAIL stall_rsp[%0d] got=%h exp=%h", i, txq[i], exp[i]);
            end
        end
        ack_delay = 1;
    endtask

    task automatic test_reset_mid();
        int n0;
        n0 = n_mem;
        txq.delete();
        ack_delay = 100;
        push_pkt(8'h01, 32'h0000_0080, 32'h0, 1'b0);
        for (int i = 0; i < 200 && !mem_req; i++) tick(1);
        checks++;
        if (mem_req !== 1'b1) begin
            failures++; $display("FAIL rmid_req got=%b exp=1", mem_req);
        end
        RST = 1'b1;
        #1;
        checks++;
        if (mem_req !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL rmid_drop got=%b/%b exp=0/0", mem_req, busy);
        end
        tick(2);
        rxq.delete();
        ack_delay = 1;
        RST = 1'b0;
        tick(2);
        push_pkt(8'h02, 32'h0000_0044, 32'h0102_0304, 1'b1);
        wait_tx(WR_LEN);
        checks++;
        if (n_mem !== n0 + 1 || last_addr !== 32'h44 || last_wdata !== 32'h0102_0304) begin
            failures++;
            $display("FAIL rmid_next got=%0d/%h/%h exp=1/00000044/01020304",
                     n_mem - n0, last_addr, last_wdata);
        end
        checks++;
        if (txq.size() !== WR_LEN || txq[0] !== 8'hA2) begin
            failures++; $display("FAIL rmid_rsp got=%0d/%h exp=%0d/a2", txq.size(), txq[0], WR_LEN);
        end
    endtask

`ifdef UART_CMD_CHECKSUM_EN
    task automatic test_checksum();
        bq_t exp;
        int n0;
        n0 = n_mem;
        txq.delete();
        mem_rdata = 32'h1234_5678;
        foreach (exp[i]) exp.delete();
        rxq.push_back(8'h01); rxq.push_back(8'h10); rxq.push_back(8'h00);
        rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h00);
        wait_tx(1);
        checks++;
        if (txq.size() !== 1 || txq[0] !== 8'hEC || n_mem !== n0) begin
            failures++;
            $display("FAIL cs_bad got=%0d/%h/%0d exp=1/ec/0", txq.size(), txq[0], n_mem - n0);
        end
        txq.delete();
        rxq.push_back(8'h01); rxq.push_back(8'h10); rxq.push_back(8'h00);
        rxq.push_back(8'h00); rxq.push_back(8'h00); rxq.push_back(8'h11);
        exp = rd_rsp(32'h1234_5678);
        wait_tx(exp.size());
        checks++;
        if (txq.size() !== 6 || n_mem !== n0 + 1) begin
            failures++; $display("FAIL cs_good got=%0d/%0d exp=6/1", txq.size(), n_mem - n0);
        end
        foreach (exp[i]) begin
            checks++;
            if (txq[i] !== exp[i]) begin
                failures++; $display("FAIL cs_rsp[%0d] got=%h exp=%h", i, txq[i], exp[i]);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write();
        test_read_late();
        test_bad_opcode();
        test_timeout();
        test_stall();
        test_reset_mid();
`ifdef UART_CMD_CHECKSUM_EN
        test_checksum();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
